vga_timing_controller: RTL

- Raster timing source for the VGA display path.
- Generates the pixel coordinates that all downstream pixel/RGB generators consume (pixel_x, pixel_y), plus hsync/vsync, the active-video flag and frame/line start pulses.
- Counters advance on a pixel clock-enable, so the block runs on the system clock.
- All outputs are registered and mutually aligned.

---
 rtl/vga_timing_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: raster timing source for the VGA display path.
// Produces pixel_x/pixel_y, hsync/vsync, video_active and line/frame start
// pulses, all registered from next-position logic so that every output
// describes the same raster position in the same cycle.
// Optional build macro: TILE_COORD_EN adds tile_col/tile_row/grid_line.
module vga_timing_controller #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
`ifdef TILE_COORD_EN
    ,
    parameter int unsigned TILE_SIZE = 16
`endif
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pixel_ce,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_active,
    output logic        line_start,
    output logic        start_of_frame
`ifdef TILE_COORD_EN
    ,
    output logic [6:0]  tile_col,
    output logic [6:0]  tile_row,
    output logic        grid_line
`endif
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          h_wrap;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          va_nxt;

    // Next raster position and the flags that describe it
    always_comb begin
        x_nxt  = pixel_x;
        y_nxt  = pixel_y;
        h_wrap = 1'b0;
        if (pixel_ce) begin
            if (pixel_x == H_MAX) begin
                x_nxt  = '0;
                h_wrap = 1'b1;
                y_nxt  = (pixel_y == V_MAX) ? '0 : pixel_y + CW'(1);
            end else begin
                x_nxt = pixel_x + CW'(1);
            end
        end
        hs_nxt = ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vs_nxt = ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        va_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    // Position and timing registers; reset parks on the last position of the frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixel_x        <= H_MAX;
            pixel_y        <= V_MAX;
            hsync          <= ~HSYNC_POL;
            vsync          <= ~VSYNC_POL;
            video_active   <= 1'b0;
            line_start     <= 1'b0;
            start_of_frame <= 1'b0;
        end else begin
            pixel_x        <= x_nxt;
            pixel_y        <= y_nxt;
            hsync          <= hs_nxt;
            vsync          <= vs_nxt;
            video_active   <= va_nxt;
            line_start     <= h_wrap;
            start_of_frame <= h_wrap && (y_nxt == '0);
        end
    end

`ifdef TILE_COORD_EN
    localparam int unsigned SUB_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int unsigned TW    = 7;

    localparam logic [SUB_W-1:0] SUB_MAX   = SUB_W'(TILE_SIZE - 1);
    localparam logic [SUB_W-1:0] SUB_X_RST = SUB_W'((H_TOTAL - 1) % TILE_SIZE);
    localparam logic [SUB_W-1:0] SUB_Y_RST = SUB_W'((V_TOTAL - 1) % TILE_SIZE);
    localparam logic [TW-1:0]    COL_RST   = TW'((H_TOTAL - 1) / TILE_SIZE);
    localparam logic [TW-1:0]    ROW_RST   = TW'((V_TOTAL - 1) / TILE_SIZE);

    logic [SUB_W-1:0] sub_x;
    logic [SUB_W-1:0] sub_y;
    logic [SUB_W-1:0] sub_x_nxt;
    logic [SUB_W-1:0] sub_y_nxt;
    logic [TW-1:0]    col_nxt;
    logic [TW-1:0]    row_nxt;

    // Incremental tile coordinates: sub-tile counters carry into tile indices
    always_comb begin
        sub_x_nxt = sub_x;
        sub_y_nxt = sub_y;
        col_nxt   = tile_col;
        row_nxt   = tile_row;
        if (pixel_ce) begin
            if (h_wrap) begin
                sub_x_nxt = '0;
                col_nxt   = '0;
                if (pixel_y == V_MAX) begin
                    sub_y_nxt = '0;
                    row_nxt   = '0;
                end else if (sub_y == SUB_MAX) begin
                    sub_y_nxt = '0;
                    row_nxt   = tile_row + TW'(1);
                end else begin
                    sub_y_nxt = sub_y + SUB_W'(1);
                end
            end else if (sub_x == SUB_MAX) begin
                sub_x_nxt = '0;
                col_nxt   = tile_col + TW'(1);
            end else begin
                sub_x_nxt = sub_x + SUB_W'(1);
            end
        end
    end

    // Tile registers, aligned with the position registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sub_x     <= SUB_X_RST;
            sub_y     <= SUB_Y_RST;
            tile_col  <= COL_RST;
            tile_row  <= ROW_RST;
            grid_line <= 1'b0;
        end else begin
            sub_x     <= sub_x_nxt;
            sub_y     <= sub_y_nxt;
            tile_col  <= col_nxt;
            tile_row  <= row_nxt;
            grid_line <= (sub_x_nxt == '0) || (sub_y_nxt == '0);
        end
    end
`endif

endmodule
